// File: rtl/reflet_mem_defs.sv
// Shared definitions for the reflet memory path: access size codes, FSM
// state encodings and the effective-access-width helper.
package reflet_mem_defs;

    localparam logic [1:0] SZ_FULL = 2'b00;
    localparam logic [1:0] SZ_32   = 2'b01;
    localparam logic [1:0] SZ_16   = 2'b10;
    localparam logic [1:0] SZ_8    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_ACK
    } mem_state_t;

    // A reduced size that is not narrower than the word collapses to a full word.
    function automatic logic [5:0] eff_bytes(input logic [1:0] size, input logic [5:0] wbytes);
        logic [5:0] b;
        case (size)
            SZ_32:   b = 6'd4;
            SZ_16:   b = 6'd2;
            SZ_8:    b = 6'd1;
            default: b = wbytes;
        endcase
        if (b > wbytes) b = wbytes;
        return b;
    endfunction

endpackage

// File: rtl/reflet_subword_mem_if.sv
// CPU-side request/acknowledge bus of the sub-word memory unit.
interface reflet_subword_mem_if #(
    parameter int wordsize = 16
);
    logic                cpu_req;
    logic                cpu_write;
    logic                cpu_signed;
    logic [1:0]          cpu_size;
    logic [wordsize-1:0] cpu_addr;
    logic [wordsize-1:0] cpu_wdata;
    logic [wordsize-1:0] cpu_rdata;
    logic                cpu_ack;
    logic                cpu_misalign;
    logic [5:0]          pop_offset;

    modport master (
        output cpu_req, cpu_write, cpu_signed, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_misalign, pop_offset
    );

    modport slave (
        input  cpu_req, cpu_write, cpu_signed, cpu_size, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_misalign, pop_offset
    );
endinterface

// File: rtl/reflet_lane_mux.sv
// Byte-lane datapath: extracts and extends a lane from a word for loads,
// and merges store data into a lane while preserving the other bytes.
module reflet_lane_mux #(
    parameter int wordsize = 16
) (
    input  logic [wordsize-1:0] word,
    input  logic [wordsize-1:0] lane_data,
    input  logic [5:0]          offset,
    input  logic [5:0]          eb,
    input  logic                is_signed,
    output logic [wordsize-1:0] ext_data,
    output logic [wordsize-1:0] merged
);
    localparam int WBYTES = wordsize / 8;

    logic [wordsize-1:0] down;
    logic [wordsize-1:0] up;
    logic                sign;

    assign down = word >> {offset, 3'b000};
    assign up   = lane_data << {offset, 3'b000};

    // Sign source is the MSB of the topmost byte of the lane.
    always_comb begin
        sign = 1'b0;
        for (int i = 0; i < WBYTES; i++) begin
            if (6'(i + 1) == eb) sign = is_signed & down[8*i+7];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WBYTES; gi++) begin : g_byte
            localparam logic [5:0] IDX = 6'(gi);
            assign merged[8*gi +: 8]   = (IDX >= offset && IDX < offset + eb) ?
                                         up[8*gi +: 8] : word[8*gi +: 8];
            assign ext_data[8*gi +: 8] = (IDX < eb) ? down[8*gi +: 8] : {8{sign}};
        end
    endgenerate

endmodule

// File: rtl/reflet_subword_mem.sv
// Memory access unit: sequences full-word and sub-word loads/stores to a
// single RAM port, doing read-modify-write for sub-word stores.
module reflet_subword_mem
    import reflet_mem_defs::*;
#(
    parameter int wordsize = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    reflet_subword_mem_if.slave   cpu,
    output logic [wordsize-1:0]   ram_addr,
    output logic                  ram_en,
    output logic                  ram_write_en,
    output logic [wordsize-1:0]   ram_wdata,
    input  logic [wordsize-1:0]   ram_rdata
);
    localparam int         WBYTES = wordsize / 8;
    localparam int         WB_LOG = $clog2(WBYTES);
    localparam logic [5:0] WB6    = 6'(WBYTES);

    mem_state_t          state_reg, state_next;
    logic [5:0]          addr_lo_reg;
    logic [1:0]          size_reg;
    logic                signed_reg, write_reg, misalign_reg;
    logic [wordsize-1:0] wdata_reg, rdata_reg, ram_wdata_reg, ram_addr_reg;

    logic [5:0]          req_eb, cur_eb, cur_off;
    logic                req_full_store, req_misalign, accept;
    logic [wordsize-1:0] lane_ext, lane_merged;

    assign req_eb         = eff_bytes(cpu.cpu_size, WB6);
    assign cur_eb         = eff_bytes(size_reg, WB6);
    assign cur_off        = addr_lo_reg & (WB6 - 6'd1) & ~(cur_eb - 6'd1);
    assign req_full_store = cpu.cpu_write && (req_eb == WB6);
    assign req_misalign   = (cpu.cpu_addr[5:0] & (req_eb - 6'd1)) != 6'd0;
    assign accept         = (state_reg == ST_IDLE) && cpu.cpu_req;

    assign cpu.pop_offset = req_eb;
    assign cpu.cpu_rdata  = rdata_reg;
    assign ram_addr       = ram_addr_reg;
    assign ram_wdata      = ram_wdata_reg;

    reflet_lane_mux #(.wordsize(wordsize)) u_lane_mux (
        .word      (ram_rdata),
        .lane_data (wdata_reg),
        .offset    (cur_off),
        .eb        (cur_eb),
        .is_signed (signed_reg),
        .ext_data  (lane_ext),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        ram_en           = 1'b0;
        ram_write_en     = 1'b0;
        cpu.cpu_ack      = 1'b0;
        cpu.cpu_misalign = 1'b0;
        case (state_reg)
            ST_IDLE: if (cpu.cpu_req) state_next = req_full_store ? ST_WR : ST_RD;
            ST_RD: begin
                ram_en     = 1'b1;
                state_next = ST_CAP;
            end
            ST_CAP:  state_next = write_reg ? ST_WR : ST_ACK;
            ST_WR: begin
                ram_en       = 1'b1;
                ram_write_en = 1'b1;
                state_next   = ST_ACK;
            end
            ST_ACK: begin
                cpu.cpu_ack      = 1'b1;
                cpu.cpu_misalign = misalign_reg;
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_lo_reg   <= '0;
            size_reg      <= SZ_FULL;
            signed_reg    <= 1'b0;
            write_reg     <= 1'b0;
            misalign_reg  <= 1'b0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            ram_wdata_reg <= '0;
            ram_addr_reg  <= '0;
        end else begin
            if (accept) begin
                addr_lo_reg  <= cpu.cpu_addr[5:0];
                size_reg     <= cpu.cpu_size;
                signed_reg   <= cpu.cpu_signed;
                write_reg    <= cpu.cpu_write;
                misalign_reg <= req_misalign;
                wdata_reg    <= cpu.cpu_wdata;
                ram_addr_reg <= cpu.cpu_addr >> WB_LOG;
                if (req_full_store) ram_wdata_reg <= cpu.cpu_wdata;
            end
            // RAM word is valid here; stores merge, loads update the result.
            if (state_reg == ST_CAP) begin
                if (write_reg) ram_wdata_reg <= lane_merged;
                else           rdata_reg     <= lane_ext;
            end
        end
    end

endmodule

// File: tb/tb_reflet_subword_mem.sv
// Scoreboard bench for reflet_subword_mem at wordsize 32 with a simple RAM model.
module tb_reflet_subword_mem;
    import reflet_mem_defs::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reflet_subword_mem_if #(.wordsize(W)) bus ();

    logic [W-1:0] ram_addr, ram_wdata, ram_rdata;
    logic         ram_en, ram_write_en;

    reflet_subword_mem #(.wordsize(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (bus.slave),
        .ram_addr     (ram_addr),
        .ram_en       (ram_en),
        .ram_write_en (ram_write_en),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    logic [W-1:0] mem [16];
    int cycle = 0;
    int reads = 0;
    int writes = 0;
    int total = 0;
    int passed = 0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (ram_en) begin
            if (ram_write_en) begin
                mem[ram_addr[3:0]] <= ram_wdata;
                writes <= writes + 1;
            end else begin
                ram_rdata <= mem[ram_addr[3:0]];
                reads <= reads + 1;
            end
        end
    end

    typedef struct {
        logic [W-1:0] rdata;
        logic         chk_rdata;
        logic         misalign;
        int           lat;
        int           issue;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (bus.cpu_ack === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_ack: got ack at cycle %0d expected none", cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_latency", W'(cycle - e.issue), W'(e.lat));
                check("misalign", W'(bus.cpu_misalign), W'(e.misalign));
                if (e.chk_rdata) check("rdata", bus.cpu_rdata, e.rdata);
                $display("ack: cycle %0d rdata %h misalign %b", cycle, bus.cpu_rdata, bus.cpu_misalign);
            end
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (bus.cpu_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", name);
        end
    endtask

    task automatic access(input string name, input logic wr, input logic sg, input logic [1:0] sz,
                          input logic [W-1:0] addr, input logic [W-1:0] wd,
                          input logic [W-1:0] exp_rd, input logic mis, input int lat);
        int r0, w0;
        logic [W-1:0] rd_before;
        exp_t e;
        r0 = reads;
        w0 = writes;
        rd_before = bus.cpu_rdata;
        bus.cpu_write  = wr;
        bus.cpu_signed = sg;
        bus.cpu_size   = sz;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wd;
        bus.cpu_req    = 1'b1;
        e.rdata = exp_rd; e.chk_rdata = !wr; e.misalign = mis; e.lat = lat; e.issue = cycle;
        sb.push_back(e);
        $display("issue %s: wr %b signed %b size %b addr %h wdata %h", name, wr, sg, sz, addr, wd);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        // Inputs change while busy; the registered request must be used.
        bus.cpu_addr  = '1;
        bus.cpu_wdata = '1;
        bus.cpu_size  = SZ_8;
        wait_ack(name);
        check({name, "_reads"}, W'(reads - r0), W'((lat == 2) ? 0 : 1));
        check({name, "_writes"}, W'(writes - w0), W'(wr ? 1 : 0));
        if (wr) check({name, "_rdata_kept"}, bus.cpu_rdata, rd_before);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] po_exp [4];
        int w0, r0;
        exp_t e;
        po_exp = '{6'd4, 6'd4, 6'd2, 6'd1};
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_signed = 1'b0;
        bus.cpu_size = SZ_FULL; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h80F11234;
        mem[1] = 32'h9ABC1234;
        bus.cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", W'(bus.cpu_ack), '0);
        check("rst_ram_en", W'(ram_en), '0);
        check("rst_ram_we", W'(ram_write_en), '0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_ram_wdata", ram_wdata, '0);
        check("rst_rdata", bus.cpu_rdata, '0);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            bus.cpu_size = 2'(s);
            #1;
            check("pop_offset", W'(bus.pop_offset), W'(po_exp[s]));
        end
        @(negedge clk);

        access("ld8u_a3",   1'b0, 1'b0, SZ_8,    32'h3, 32'h0,      32'h00000080, 1'b0, 3);
        access("ld16s_a6",  1'b0, 1'b1, SZ_16,   32'h6, 32'h0,      32'hFFFF9ABC, 1'b0, 3);
        mem[1] = 32'h11223344;
        access("st8_a5",    1'b1, 1'b0, SZ_8,    32'h5, 32'h55,     32'h0,        1'b0, 4);
        check("st8_word", mem[1], 32'h11225544);
        access("st32_full", 1'b1, 1'b0, SZ_32,   32'h8, 32'hBEEFCAFE, 32'h0,      1'b0, 2);
        check("st32_word", mem[2], 32'hBEEFCAFE);
        access("ld16_mis",  1'b0, 1'b0, SZ_16,   32'h3, 32'h0,      32'h000080F1, 1'b1, 3);
        access("ld8s_neg",  1'b0, 1'b1, SZ_8,    32'h3, 32'h0,      32'hFFFFFF80, 1'b0, 3);
        access("ld8s_pos",  1'b0, 1'b1, SZ_8,    32'h1, 32'h0,      32'h00000012, 1'b0, 3);
        access("st16_a10",  1'b1, 1'b0, SZ_16,   32'hA, 32'h1234A5A5, 32'h0,      1'b0, 4);
        check("st16_word", mem[2], 32'hA5A5CAFE);
        access("ldfull_a8", 1'b0, 1'b1, SZ_FULL, 32'h8, 32'h0,      32'hA5A5CAFE, 1'b0, 3);
        access("st16_mis",  1'b1, 1'b0, SZ_16,   32'h7, 32'h0000BEAD, 32'h0,      1'b1, 4);
        check("st16_mis_word", mem[1], 32'hBEAD5544);

        // Request held high through ACK must not start a second access.
        r0 = reads;
        bus.cpu_write = 1'b0; bus.cpu_signed = 1'b0; bus.cpu_size = SZ_8;
        bus.cpu_addr = 32'h0; bus.cpu_req = 1'b1;
        e.rdata = 32'h00000034; e.chk_rdata = 1'b1; e.misalign = 1'b0; e.lat = 3; e.issue = cycle;
        sb.push_back(e);
        $display("issue held_req: load 8b addr 0 with req held through ack");
        @(negedge clk);
        wait_ack("held_req");
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        check("held_req_reads", W'(reads - r0), W'(1));

        // Reset during CAP of a sub-word store drops the write.
        w0 = writes;
        bus.cpu_write = 1'b1; bus.cpu_size = SZ_8; bus.cpu_addr = 32'h5;
        bus.cpu_wdata = 32'h77; bus.cpu_req = 1'b1;
        $display("issue rst_mid: store 8b addr 5, reset in CAP");
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("rst_mid_rd_addr", ram_addr, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", W'(bus.cpu_ack), '0);
        check("rst_mid_ram_en", W'(ram_en), '0);
        check("rst_mid_ram_we", W'(ram_write_en), '0);
        check("rst_mid_ram_addr", ram_addr, '0);
        check("rst_mid_ram_wdata", ram_wdata, '0);
        check("rst_mid_rdata", bus.cpu_rdata, '0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_writes", W'(writes - w0), '0);
        check("rst_mid_word", mem[1], 32'hBEAD5544);

        check("sb_empty", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
